// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, walker state type and word/byte helpers
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned KW = 128;

  typedef enum logic {IDLE, RUN} ks_state_e;

  // Round constant for the step that produced round key 'times'; index 0 never used.
  function automatic logic [7:0] rcon(input logic [3:0] times);
    case (times)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] key_word(input logic [KW-1:0] k, input int unsigned idx);
    key_word = k[KW-1-32*idx -: 32];
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input int unsigned idx);
    word_byte = w[31-8*idx -: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box (GF(2^8) inverse plus affine map)
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    gf_mul = acc;
  endfunction

  // Inverse as a^254 by square-and-multiply; an input of 0 falls out as 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    gf_inv = r;
  endfunction

  logic [7:0] inv;

  assign inv   = gf_inv(in_i);
  assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - walks the AES-128 key schedule from round NR down to round 0
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key,
  output logic [KW-1:0] keyout,
  output logic [3:0]    times,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          done
);

  ks_state_e     state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [3:0]    times_q, times_d;
  logic          done_q, done_d;

  logic [31:0]   w0, w1, w2, w3, n3, rot_n3, sub_n3;
  logic [KW-1:0] prev_key;

  assign w0     = key_word(key_q, 0);
  assign w1     = key_word(key_q, 1);
  assign w2     = key_word(key_q, 2);
  assign w3     = key_word(key_q, 3);
  assign n3     = w3 ^ w2;
  assign rot_n3 = rot_word(n3);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (word_byte(rot_n3, b)),
      .out_o (sub_n3[31-8*b -: 8])
    );
  end

  // Undo one forward step: later words are XOR chains, w0 needs the g() term of n3.
  assign prev_key = {w0 ^ sub_n3 ^ {rcon(times_q), 24'h0}, w1 ^ w0, w2 ^ w1, n3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    times_d = times_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          times_d = 4'(NR);
          state_d = RUN;
        end
      end
      RUN: begin
        if (ready) begin
          if (times_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key;
            times_d = times_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      times_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      times_q <= times_d;
      done_q  <= done_d;
    end
  end

  assign keyout = key_q;
  assign times  = times_q;
  assign valid  = (state_q == RUN);
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - randomized self-checking bench for the inverse key walker
module tb_aes_inv_key_schedule;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         ready = 1'b0;
  logic [127:0] key   = '0;
  logic [127:0] keyout;
  logic [3:0]   times;
  logic         valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_keys [11];
  logic [131:0] mon_q [$];
  int           done_cnt = 0;
  int           x_cnt = 0;
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  aes_inv_key_schedule dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key    (key),
    .keyout (keyout),
    .times  (times),
    .valid  (valid),
    .ready  (ready),
    .busy   (busy),
    .done   (done)
  );

  // Record every accepted key, every done pulse and any X on the outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid && ready) mon_q.push_back({times, keyout});
      if (done) done_cnt++;
      if ((^keyout) === 1'bx || (^times) === 1'bx || (^{valid, busy, done}) === 1'bx) x_cnt++;
    end
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from exp/log tables over generator 3, then the affine map bit by bit.
  task automatic build_sbox();
    logic [7:0] expt [256];
    int         logt [256];
    logic [7:0] e, inv, s;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      expt[i] = e;
      logt[e] = i;
      e = e ^ xt(e);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : expt[(255 - logt[x]) % 255];
      s = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = s[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sbox_tab[x] = s;
    end
  endtask

  // Forward FIPS-197 expansion from the cipher key; exp_keys[r] is round key r.
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output bit ok);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (keyout !== '0 || times !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got keyout=%h times=%0d valid=%b busy=%b done=%b, want all zero",
               keyout, times, valid, busy, done);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got valid=%b busy=%b, want 0 0", valid, busy);
    end
  endtask

  task automatic test_fips_walk();
    int q0, d0;
    bit ok;
    expand(FIPS_K0);
    ready = 1'b1;
    q0 = mon_q.size();
    d0 = done_cnt;
    load(FIPS_K10);
    checks++;
    if (times !== 4'd10 || keyout !== FIPS_K10 || valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fips_load: got times=%0d keyout=%h valid=%b busy=%b, want 10 %h 1 1",
               times, keyout, valid, busy, FIPS_K10);
    end
    tick();
    checks++;
    if (times !== 4'd9 || keyout !== FIPS_K9) begin
      errors++;
      $display("FAIL fips_round9: got times=%0d keyout=%h, want 9 %h", times, keyout, FIPS_K9);
    end
    run_to_done(40, ok);
    checks++;
    if (!ok || valid !== 1'b0 || busy !== 1'b0 || times !== 4'd0 || keyout !== FIPS_K0) begin
      errors++;
      $display("FAIL fips_done: got done=%b valid=%b busy=%b times=%0d keyout=%h, want 1 0 0 0 %h",
               done, valid, busy, times, keyout, FIPS_K0);
    end
    tick();
    tick();
    checks++;
    if (done_cnt - d0 !== 1 || done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_done_once: got pulses=%0d done=%b valid=%b, want 1 0 0", done_cnt - d0, done, valid);
    end
    checks++;
    if (mon_q.size() - q0 !== 11) begin
      errors++;
      $display("FAIL fips_count: got %0d keys, want 11", mon_q.size() - q0);
    end
    for (int i = 0; i < 11; i++) begin
      if (q0 + i < mon_q.size()) begin
        checks++;
        if (mon_q[q0+i] !== {4'(10 - i), exp_keys[10-i]}) begin
          errors++;
          $display("FAIL fips_key%0d: got %h, want %h", 10 - i, mon_q[q0+i], {4'(10 - i), exp_keys[10-i]});
        end
      end
    end
    if (q0 + 10 < mon_q.size()) begin
      checks++;
      if (mon_q[q0+9][127:0] !== FIPS_K1 || mon_q[q0+10][127:0] !== FIPS_K0) begin
        errors++;
        $display("FAIL fips_tail: got k1=%h k0=%h, want %h %h",
                 mon_q[q0+9][127:0], mon_q[q0+10][127:0], FIPS_K1, FIPS_K0);
      end
    end
  endtask

  task automatic test_backpressure();
    int q0, n;
    bit ok;
    logic [127:0] hold_k;
    logic [131:0] hold;
    bit stalled;
    expand(rand_key());
    ready = 1'b1;
    load(exp_keys[10]);
    n = 0;
    while (times !== 4'd5 && n < 20) begin
      tick();
      n++;
    end
    ready  = 1'b0;
    hold_k = keyout;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (keyout !== hold_k || times !== 4'd5 || valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got times=%0d keyout=%h valid=%b, want 5 %h 1", c, times, keyout, valid, hold_k);
      end
    end
    ready = 1'b1;
    tick();
    checks++;
    if (times !== 4'd4 || keyout !== exp_keys[4]) begin
      errors++;
      $display("FAIL stall_release: got times=%0d keyout=%h, want 4 %h", times, keyout, exp_keys[4]);
    end
    run_to_done(20, ok);
    tick();

    expand(FIPS_K0);
    q0 = mon_q.size();
    load(FIPS_K10);
    n = 0;
    while (!done && n < 300) begin
      ready   = 1'($urandom_range(0, 1));
      stalled = valid && !ready;
      hold    = {times, keyout};
      tick();
      n++;
      if (stalled) begin
        checks++;
        if ({times, keyout} !== hold) begin
          errors++;
          $display("FAIL rand_stall_hold: got %h, want %h", {times, keyout}, hold);
        end
      end
    end
    ready = 1'b1;
    checks++;
    if (mon_q.size() - q0 !== 11 || !done) begin
      errors++;
      $display("FAIL rand_ready_count: got %0d keys done=%b, want 11 1", mon_q.size() - q0, done);
    end
    for (int i = 0; i < 11; i++) begin
      if (q0 + i < mon_q.size()) begin
        checks++;
        if (mon_q[q0+i] !== {4'(10 - i), exp_keys[10-i]}) begin
          errors++;
          $display("FAIL rand_ready_key%0d: got %h, want %h", 10 - i, mon_q[q0+i], {4'(10 - i), exp_keys[10-i]});
        end
      end
    end
    tick();
  endtask

  task automatic test_restart_ignored();
    int q0, d0, n;
    bit ok;
    expand(rand_key());
    ready = 1'b1;
    q0 = mon_q.size();
    d0 = done_cnt;
    load(exp_keys[10]);
    n = 0;
    while (times !== 4'd7 && n < 20) begin
      tick();
      n++;
    end
    start = 1'b1;
    key   = rand_key();
    tick();
    start = 1'b0;
    checks++;
    if (times !== 4'd6 || keyout !== exp_keys[6]) begin
      errors++;
      $display("FAIL restart_ignored: got times=%0d keyout=%h, want 6 %h", times, keyout, exp_keys[6]);
    end
    run_to_done(20, ok);
    tick();
    checks++;
    if (!ok || mon_q.size() - q0 !== 11 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL restart_count: got done=%b keys=%0d pulses=%0d, want 1 11 1", ok, mon_q.size() - q0, done_cnt - d0);
    end
    for (int i = 0; i < 11; i++) begin
      if (q0 + i < mon_q.size()) begin
        checks++;
        if (mon_q[q0+i] !== {4'(10 - i), exp_keys[10-i]}) begin
          errors++;
          $display("FAIL restart_key%0d: got %h, want %h", 10 - i, mon_q[q0+i], {4'(10 - i), exp_keys[10-i]});
        end
      end
    end
  endtask

  task automatic test_reset_midwalk();
    int q0, d0, n;
    bit ok;
    expand(rand_key());
    ready = 1'b1;
    load(exp_keys[10]);
    n = 0;
    while (times !== 4'd3 && n < 20) begin
      tick();
      n++;
    end
    d0  = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (keyout !== '0 || times !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midwalk_reset: got keyout=%h times=%0d valid=%b busy=%b done=%b, want all zero",
               keyout, times, valid, busy, done);
    end
    tick();
    tick();
    checks++;
    if (done_cnt !== d0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midwalk_no_done: got pulses=%0d valid=%b, want 0 0", done_cnt - d0, valid);
    end
    expand(FIPS_K0);
    q0 = mon_q.size();
    load(FIPS_K10);
    run_to_done(20, ok);
    checks++;
    if (!ok || mon_q.size() - q0 !== 11) begin
      errors++;
      $display("FAIL midwalk_rewalk_count: got done=%b keys=%0d, want 1 11", ok, mon_q.size() - q0);
    end
    for (int i = 0; i < 11; i++) begin
      if (q0 + i < mon_q.size()) begin
        checks++;
        if (mon_q[q0+i] !== {4'(10 - i), exp_keys[10-i]}) begin
          errors++;
          $display("FAIL midwalk_key%0d: got %h, want %h", 10 - i, mon_q[q0+i], {4'(10 - i), exp_keys[10-i]});
        end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int q0;
    bit ok;
    logic [127:0] kb0;
    expand(rand_key());
    ready = 1'b1;
    q0 = mon_q.size();
    load(exp_keys[10]);
    run_to_done(20, ok);
    checks++;
    if (!ok || mon_q.size() - q0 !== 11 || mon_q[mon_q.size()-1] !== {4'd0, exp_keys[0]}) begin
      errors++;
      $display("FAIL b2b_first_walk: got done=%b keys=%0d, want 1 11 ending in %h", ok, mon_q.size() - q0, exp_keys[0]);
    end
    kb0 = rand_key();
    expand(kb0);
    q0 = mon_q.size();
    start = 1'b1;
    key   = exp_keys[10];
    tick();
    start = 1'b0;
    checks++;
    if (times !== 4'd10 || keyout !== exp_keys[10] || valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got times=%0d keyout=%h valid=%b, want 10 %h 1", times, keyout, valid, exp_keys[10]);
    end
    run_to_done(20, ok);
    tick();
    checks++;
    if (!ok || mon_q.size() - q0 !== 11) begin
      errors++;
      $display("FAIL b2b_second_count: got done=%b keys=%0d, want 1 11", ok, mon_q.size() - q0);
    end
    for (int i = 0; i < 11; i++) begin
      if (q0 + i < mon_q.size()) begin
        checks++;
        if (mon_q[q0+i] !== {4'(10 - i), exp_keys[10-i]}) begin
          errors++;
          $display("FAIL b2b_key%0d: got %h, want %h", 10 - i, mon_q[q0+i], {4'(10 - i), exp_keys[10-i]});
        end
      end
    end
    checks++;
    if (x_cnt !== 0) begin
      errors++;
      $display("FAIL x_free: got %0d cycles with X on outputs, want 0", x_cnt);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_walk();
    test_backpressure();
    test_restart_ignored();
    test_reset_midwalk();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
Decryption-side counterpart of the round-key store. It is loaded once with the final (round-10) AES-128 round key. It then walks the key schedule backwards, emitting round keys 10, 9, …, 0 one per accepted handshake. The inverse-cipher datapath consumes these keys in order, so no 11-entry key store is needed on the decrypt path.

Parameters:
NR, 10, number of AES-128 rounds; fixes the first emitted round index and the Rcon sequence length.
KW, 128, round-key width in bits.

Ports:
clk  input  1  sole clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  load request; sampled only in IDLE.
key  input  128  round-NR key, captured when start is accepted.
keyout  output  128  current round key, word w0 in bits [127:96].
times  output  4  round index of keyout.
valid  output  1  keyout/times are meaningful.
ready  input  1  downstream accepts keyout this cycle.
busy  output  1  high while not IDLE.
done  output  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: keyout=0, times=0, valid=0, busy=0, done=0, state=IDLE.
- rst asserted mid-walk aborts immediately; no done pulse is produced.
- States: IDLE, RUN.
- IDLE with start=1:
  - next cycle: keyout=key, times=NR, valid=1, busy=1, state=RUN.
  - load latency is 1 cycle.
- IDLE with start=0: outputs hold, valid=0.
- RUN with valid && !ready: keyout and times hold stable; no change is allowed while stalled.
- RUN with valid && ready && times>0: the next cycle presents round times-1:
  - w0..w3 are the current words, w0 = MSB word.
  - n3 = w3^w2; n2 = w2^w1; n1 = w1^w0.
  - n0 = w0 ^ SubWord(RotWord(n3)) ^ {Rcon(times),24'h0}.
  - RotWord rotates bytes left by one: {b1,b2,b3,b0}.
  - valid stays 1, so one key is produced per cycle at full throughput.
- Rcon(i), i=1..10: 01,02,04,08,10,20,40,80,1b,36. Index 0 is unused and is treated as 00.
- RUN with valid && ready && times==0:
  - next cycle: valid=0, busy=0, done=1 for exactly one cycle, state=IDLE.
  - keyout and times keep their last values.
- start during RUN is ignored and does not restart the walk.
- start in the same cycle done is high is accepted, since the block is already in IDLE.
- Next-key logic is combinational from the registered keyout. No multicycle paths.

Decomposition:
- Shared package aes_pkg holds: the Rcon table as a function rcon(times), the round-count constant NR=10, and the word/byte slicing helpers.
- One sub-module, aes_sbox: combinational 8-bit to 8-bit forward S-box, instantiated 4 times for SubWord. It is shareable with the encrypt key path.

Test Plan:
1. FIPS-197 load:
   - Stimulus: start=1 with key=d014f9a8c9ee2589e13f0cc8b6630ca6, ready=1.
   - Response: the cycle after load, times=10, keyout=d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Next cycle: times=9, keyout=ac7766f319fadc2128d12941575c006e.
2. Full walk:
   - Stimulus: continue scenario 1 with ready held at 1.
   - Response: times=1 gives keyout=a0fafe1788542cb123a339392a6c7605.
   - times=0 gives keyout=2b7e151628aed2a6abf7158809cf4f3c.
   - done pulses exactly once, one cycle later; valid=0 thereafter.
   - All 11 keys are compared against the forward golden table.
3. Backpressure:
   - Stimulus: drop ready for 3 cycles while times=5.
   - Response: keyout/times stay constant for those 3 cycles; times=4 appears on the cycle after ready returns.
   - A randomized ready pattern produces the same 11-key sequence as scenario 2.
4. Restart ignored:
   - Stimulus: pulse start with a different key while times=7.
   - Response: the sequence continues unchanged to round 0.
5. Reset mid-walk:
   - Stimulus: assert rst for 1 cycle at times=3.
   - Response: the next cycle has all outputs 0 and no done pulse.
   - A fresh start then reproduces scenario 2.
6. Back-to-back:
   - Stimulus: start asserted in the same cycle as done.
   - Response: a new walk begins with times=10 the following cycle.
   - Output is X-free throughout: ^keyout !== x.
